// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: write-pointer sync, empty flag, memory read, FWFT output stage.
// Optional read-domain occupancy count is built when FIFO_RD_COUNT_EN is defined.
module fifo_read_ctrl #(
    parameter int unsigned ptr_width  = 11,
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 1024
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [ptr_width-1:0]  wptr_gray,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  ren,
    output logic [ptr_width-2:0]  raddr,
    output logic                  empty,
    output logic [ptr_width-1:0]  rptr_gray,
    output logic [data_width-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ptr_width-1:0]  rd_count
);

    localparam int unsigned addr_width = $clog2(depth);

    logic [ptr_width-1:0] wq1;
    logic [ptr_width-1:0] wq2;
    logic [ptr_width-1:0] rbin;
    logic [ptr_width-1:0] rbin_next;
    logic [ptr_width-1:0] rgray_next;

    // Pop only when a word is available and the output slot is free or being drained.
    assign ren        = !empty && (!dout_valid || dout_ready);
    assign raddr      = rbin[addr_width-1:0];
    assign rbin_next  = rbin + ptr_width'(ren);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            wq1        <= '0;
            wq2        <= '0;
            rbin       <= '0;
            rptr_gray  <= '0;
            empty      <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            wq1       <= wptr_gray;
            wq2       <= wq1;
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            // Compare against the post-pop pointer so the last word asserts empty at once.
            empty     <= (rgray_next == wq2);
            if (ren) begin
                dout       <= mem_rdata;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef FIFO_RD_COUNT_EN
    logic [ptr_width-1:0] wbin_s;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < int'(ptr_width); i++) begin
            wbin_s[i] = ^(wq2 >> i);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_count <= '0;
        end else begin
            rd_count <= wbin_s - rbin_next;
        end
    end
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_read_ctrl;

    localparam int unsigned PW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

`ifdef FIFO_RD_COUNT_EN
    localparam logic [PW-1:0] CNT_EXP = 11'd9;
`else
    localparam logic [PW-1:0] CNT_EXP = 11'd0;
`endif

    logic          clk = 1'b0;
    logic          rrst = 1'b1;
    logic [PW-1:0] wptr_gray = '0;
    logic [DW-1:0] mem_rdata;
    logic          ren;
    logic [PW-2:0] raddr;
    logic          empty;
    logic [PW-1:0] rptr_gray;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [PW-1:0] rd_count;

    logic [DW-1:0] mem [DEPTH];
    assign mem_rdata = mem[raddr];

    // Reference state: counts of words written/popped, write pointer as seen by the reader, FIFO contents.
    logic [PW-1:0] wbin    = '0;
    logic [PW-1:0] m_rd    = '0;
    logic [PW-1:0] s1      = '0;
    logic [PW-1:0] s2      = '0;
    logic [PW-1:0] m_cnt   = '0;
    logic          m_empty = 1'b1;
    logic          m_dv    = 1'b0;
    logic [DW-1:0] m_dout  = '0;
    logic [DW-1:0] sb [$];

    int n_chk = 0;
    int n_bad = 0;
    bit comb_on = 1'b0;

    always #5 clk = ~clk;

    fifo_read_ctrl dut (
        .rclk       (clk),
        .rrst       (rrst),
        .wptr_gray  (wptr_gray),
        .mem_rdata  (mem_rdata),
        .ren        (ren),
        .raddr      (raddr),
        .empty      (empty),
        .rptr_gray  (rptr_gray),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rd_count   (rd_count)
    );

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One rclk edge: advance the model, then compare registered outputs at the falling edge.
    task automatic tick();
        logic pop;
        @(posedge clk);
        if (rrst) begin
            m_rd = '0; s1 = '0; s2 = '0; m_cnt = '0;
            m_empty = 1'b1; m_dv = 1'b0; m_dout = '0;
        end else begin
            pop = !m_empty && (!m_dv || dout_ready);
            if (pop) begin
                m_rd   = m_rd + 11'd1;
                m_dout = (sb.size() > 0) ? sb.pop_front() : '0;
                m_dv   = 1'b1;
            end else if (dout_ready) begin
                m_dv = 1'b0;
            end
            m_empty = (m_rd == s2);
            m_cnt   = s2 - m_rd;
            s2 = s1;
            s1 = wbin;
        end
        @(negedge clk);
        chk("empty", 64'(empty), 64'(m_empty));
        chk("dout_valid", 64'(dout_valid), 64'(m_dv));
        chk("dout", 64'(dout), 64'(m_dout));
        chk("rptr_gray", 64'(rptr_gray), 64'(gray(m_rd)));
`ifdef FIFO_RD_COUNT_EN
        chk("rd_count", 64'(rd_count), 64'(m_cnt));
`else
        chk("rd_count", 64'(rd_count), 64'd0);
`endif
    endtask

    // Apply inputs for the coming edge (write side included), then check the combinational outputs.
    task automatic drive(input logic rst, input logic rdy, input logic wr, input logic [DW-1:0] d);
        logic [PW-1:0] occ;
        rrst = rst;
        dout_ready = rdy;
        if (rst) begin
            wbin = '0;
            sb.delete();
        end else if (wr) begin
            occ = wbin - m_rd;
            if (occ < 11'd1024) begin
                mem[wbin[PW-2:0]] = d;
                sb.push_back(d);
                wbin = wbin + 11'd1;
            end
        end
        wptr_gray = gray(wbin);
        #1;
        if (comb_on) begin
            chk("ren", 64'(ren), 64'(!m_empty && (!m_dv || rdy)));
            chk("raddr", 64'(raddr), 64'(m_rd[PW-2:0]));
        end
    endtask

    task automatic cycle(input logic rst, input logic rdy, input logic wr, input logic [DW-1:0] d);
        drive(rst, rdy, wr, d);
        tick();
    endtask

    task automatic wait_dv(input logic rdy, input int budget);
        int n = 0;
        while (!dout_valid && n < budget) begin
            cycle(1'b0, rdy, 1'b0, '0);
            n++;
        end
        chk("wait_dv_timeout", 64'(dout_valid), 64'd1);
    endtask

    initial begin
        int wp;
        int rp;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

        // Reset
        cycle(1'b1, 1'b1, 1'b0, '0);
        comb_on = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_dv", 64'(dout_valid), 64'd0);
        chk("rst_rptr", 64'(rptr_gray), 64'd0);
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("rst_ren", 64'(ren), 64'd0);
        chk("rst_raddr", 64'(raddr), 64'd0);
        tick();

        // Single word latency
        drive(1'b0, 1'b1, 1'b1, 32'hA5A5_0001);
        tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("sw_empty_e2", 64'(empty), 64'd1);
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("sw_empty_e3", 64'(empty), 64'd0);
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("sw_ren", 64'(ren), 64'd1);
        tick();
        chk("sw_dv_e4", 64'(dout_valid), 64'd1);
        chk("sw_dout", 64'(dout), 64'hA5A5_0001);
        chk("sw_empty_e4", 64'(empty), 64'd1);
        chk("sw_rptr", 64'(rptr_gray), 64'd1);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("sw_dv_drop", 64'(dout_valid), 64'd0);

        // Backpressure
        cycle(1'b0, 1'b0, 1'b1, 32'hB000_0000);
        cycle(1'b0, 1'b0, 1'b1, 32'hB000_0001);
        cycle(1'b0, 1'b0, 1'b1, 32'hB000_0002);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, '0);
        chk("bp_dout", 64'(dout), 64'hB000_0000);
        chk("bp_dv", 64'(dout_valid), 64'd1);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("bp_ren", 64'(ren), 64'd0);
        chk("bp_raddr", 64'(raddr), 64'd2);
        tick();
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("bp_w2", 64'(dout), 64'hB000_0001);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("bp_w3", 64'(dout), 64'hB000_0002);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("bp_drain", 64'(dout_valid), 64'd0);

        // Occupancy count with ten words written and one held in dout
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 32'hC000_0000 + DW'(i));
        repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);
        chk("cnt_settled", 64'(rd_count), 64'(CNT_EXP));
        chk("cnt_head", 64'(dout), 64'hC000_0000);

        // Pointer wrap
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 1023; i++) cycle(1'b0, 1'b1, 1'b1, 32'hD000_0000 + DW'(i));
        repeat (8) cycle(1'b0, 1'b1, 1'b0, '0);
        chk("wrap_raddr_pre", 64'(raddr), 64'd1023);
        chk("wrap_rptr_pre", 64'(rptr_gray), 64'h200);
        cycle(1'b0, 1'b1, 1'b1, 32'hE000_0000);
        wait_dv(1'b1, 10);
        chk("wrap_rptr_a", 64'(rptr_gray), 64'h600);
        chk("wrap_raddr_a", 64'(raddr), 64'd0);
        chk("wrap_dout_a", 64'(dout), 64'hE000_0000);
        cycle(1'b0, 1'b1, 1'b1, 32'hE000_0001);
        wait_dv(1'b1, 10);
        chk("wrap_rptr_b", 64'(rptr_gray), 64'h601);
        chk("wrap_raddr_b", 64'(raddr), 64'd1);
        chk("wrap_dout_b", 64'(dout), 64'hE000_0001);

        // Randomized traffic with varying write and accept rates
        for (int blk = 0; blk < 8; blk++) begin
            wp = int'($urandom_range(20, 95));
            rp = int'($urandom_range(5, 95));
            repeat (600) cycle(1'b0, int'($urandom_range(0, 99)) < rp,
                               int'($urandom_range(0, 99)) < wp, $urandom);
        end

        // Reset while a word is held
        cycle(1'b0, 1'b0, 1'b1, 32'hF00D_0001);
        wait_dv(1'b0, 10);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk("mr_dv", 64'(dout_valid), 64'd0);
        chk("mr_dout", 64'(dout), 64'd0);
        chk("mr_empty", 64'(empty), 64'd1);
        chk("mr_rptr", 64'(rptr_gray), 64'd0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("mr_raddr", 64'(raddr), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the asynchronous FIFO, living entirely in the read clock domain. It synchronizes the write pointer, generates `empty`, drives `ren`/`raddr` into `fifo_memory`, and publishes its own Gray read pointer back to the write domain. Read data is registered into a first-word-fall-through output stage with a valid/ready handshake.

## Interface
- `ptr_width`, 11, pointer width; MSB is the wrap bit, address is `ptr_width-1` bits.
- `data_width`, 32, word width.
- `depth`, 1024, number of entries; must equal 2^(`ptr_width`-1).

Ports (one clock; reset is synchronous and active-high):
- `rclk`  in  1  read-domain clock.
- `rrst`  in  1  synchronous active-high reset.
- `wptr_gray`  in  ptr_width  write pointer, Gray coded, asynchronous to `rclk`.
- `mem_rdata`  in  data_width  combinational read data from memory at `raddr`.
- `ren`  out  1  memory read strobe (pop this cycle).
- `raddr`  out  ptr_width-1  memory read address.
- `empty`  out  1  FIFO empty, registered.
- `rptr_gray`  out  ptr_width  read pointer, Gray coded, registered, to write-domain synchronizer.
- `dout`  out  data_width  output word.
- `dout_valid`  out  1  `dout` holds a word.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `rd_count`  out  ptr_width  occupancy in the read domain (see Configuration).

## Operation
- Synchronizer: two flops `wq1`, `wq2` clocked by `rclk`; `wq1 <= wptr_gray`, `wq2 <= wq1`.
- Binary read pointer `rbin` (ptr_width bits). `raddr = rbin[ptr_width-2:0]`.
- `ren = !empty && (!dout_valid || dout_ready)`; combinational.
- `rbin_next = rbin + ren` (modulo 2^ptr_width, natural wrap). `rgray_next = rbin_next ^ (rbin_next >> 1)`.
- Every edge: `rbin <= rbin_next`, `rptr_gray <= rgray_next`, `empty <= (rgray_next == wq2)`.
- Output stage: if `ren`, `dout <= mem_rdata`, `dout_valid <= 1`; else if `dout_ready`, `dout_valid <= 0`; else hold.
- Transfer occurs on an edge with `dout_valid && dout_ready`. A simultaneous pop and accept replaces `dout` with the next word, and `dout_valid` stays 1.
- `dout` holds its value while `dout_valid && !dout_ready`. No pop occurs while the output is stalled.
- Wrap: when `raddr` passes from `depth-1` to 0, the MSB of `rbin` toggles. No special handling is needed.

## Timing
- Reset values: `wq1`=0, `wq2`=0, `rbin`=0, `rptr_gray`=0, `empty`=1, `dout`=0, `dout_valid`=0, `rd_count`=0. Therefore `ren`=0 during and immediately after reset.
- Reset mid-operation: all state returns to reset values on the next `rclk` edge, and the word in `dout` is discarded. The write side must be reset in the same window.
- Empty deassert latency: `wptr_gray` stable before edge 1 gives `wq2` at edge 2 and `empty`=0 at edge 3. `ren`=1 in the following cycle, and `dout_valid`=1 at edge 4.
- Empty assert is immediate: a pop that consumes the last synchronized word sets `empty` at that same edge. There is never a read past the write pointer.
- Throughput: one word per `rclk` while `dout_ready`=1 and `empty`=0.
- `empty` is pessimistic. It may remain 1 for up to 3 cycles after a write, and it is never falsely 0.

## Configuration
- `FIFO_RD_COUNT_EN` defined:
  - `wq2` is Gray-to-binary converted into `wbin_s`.
  - `rd_count <= wbin_s - rbin_next` (ptr_width bits, modulo) every edge.
  - Range is 0..`depth`. The value is pessimistically low by the synchronizer delay.
- Not defined: `rd_count` is tied to 0 and no conversion logic is built.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert `rrst` 2 cycles with `wptr_gray`=0 -> `empty`=1, `dout_valid`=0, `rptr_gray`=0, `raddr`=0, `ren`=0.
- Single word: memory[0]=32'hA5A5_0001, `wptr_gray` 0->1, `dout_ready`=1 -> `empty`=0 at edge 3, `ren`=1 one cycle, `dout`=A5A5_0001 with `dout_valid` at edge 4, `empty`=1 again at edge 4, `rptr_gray`=1.
- Backpressure: 3 words written, `dout_ready`=0 -> first word held in `dout`, `ren`=0, `raddr` stays at 1. Raise `dout_ready` -> words 2 and 3 appear on consecutive cycles.
- Wrap: preload `rbin`=1023 by streaming, then write 2 words -> `raddr` goes 1023 then 0, `rptr_gray` passes from Gray(1023) to Gray(1024)=11'h600, and data order is preserved.
- Count build (`FIFO_RD_COUNT_EN`): `wptr_gray`=Gray(10), `dout_ready`=0 -> `rd_count` settles to 9 (one word held in `dout`). Without the macro, `rd_count`=0 throughout.
- Mid-stream reset: assert `rrst` while `dout_valid`=1 -> next edge `dout_valid`=0, `dout`=0, `empty`=1, `rbin`=0.
